watchdog_timer: RTL and testbench



---
 rtl/watchdog_pkg.sv | 16 +
 rtl/watchdog_timer_sync_ff.sv | 35 +++
 rtl/watchdog_timer.sv | 104 ++++++++++
 tb/tb_watchdog_timer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// rtl/watchdog_pkg.sv - shared constants for the watchdog timer
// Purpose: default sizing and the idle levels of the serial load pins,
//          shared by the top level and its synchronizers.
// Ports:   none (package).
package watchdog_pkg;

  localparam int WIDTH_DEFAULT       = 32;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Idle levels of the serial interface; synchronizers and edge
  // history flops reset to these so no edge is seen after reset.
  localparam logic SCLK_IDLE = 1'b1;
  localparam logic SEL_IDLE  = 1'b0;
  localparam logic IN_IDLE   = 1'b0;

endpackage

// File: rtl/watchdog_timer_sync_ff.sv
// rtl/watchdog_timer_sync_ff.sv - N-stage synchronizer with a reset value
// Purpose: brings one asynchronous pin into the clk domain.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, loads RST_VAL into every stage
//   d   - asynchronous input
//   q   - synchronized output (last stage)
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {STAGES{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/watchdog_timer.sv
// rtl/watchdog_timer.sv - programmable periodic watchdog timer with serial load
// Purpose: a WIDTH-bit period ("top") is shifted in MSB first over a slow
//          3-wire interface; the block then pulses woof every top+1 cycles.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   sclk - serial clock (async, idle high), data taken on its rising edge
//   in   - serial data, MSB first
//   sel  - frame enable, high for the whole frame, falling edge commits
//   woof - registered single-cycle timeout pulse
module watchdog_timer
  import watchdog_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic in,
  input  logic sel,
  output logic woof
);

  logic sclk_sync;
  logic in_sync;
  logic sel_sync;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_sync)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(IN_IDLE)) u_sync_in (
    .clk(clk), .rst(rst), .d(in), .q(in_sync)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SEL_IDLE)) u_sync_sel (
    .clk(clk), .rst(rst), .d(sel), .q(sel_sync)
  );

  logic             sclk_hist_q, sclk_hist_d;
  logic             sel_hist_q,  sel_hist_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] top_q,   top_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             woof_q,  woof_d;

  logic sclk_rise;
  logic sel_rise;
  logic sel_fall;

  always_comb begin
    sclk_rise   = sclk_sync & ~sclk_hist_q;
    sel_rise    = sel_sync & ~sel_hist_q;
    sel_fall    = ~sel_sync & sel_hist_q;
    sclk_hist_d = sclk_sync;
    sel_hist_d  = sel_sync;

    shift_d = shift_q;
    top_d   = top_q;
    count_d = count_q;
    woof_d  = 1'b0;

    // A new frame starts from zero so short frames come out right-aligned.
    if (sel_rise) begin
      shift_d = '0;
    end else if (sclk_rise && sel_sync) begin
      shift_d = {shift_q[WIDTH-2:0], in_sync};
    end

    // Commit wins over the compare: the old period never fires on the
    // cycle the new one is taken. During a frame the timer is paused.
    if (sel_fall) begin
      top_d   = shift_q;
      count_d = '0;
    end else if (sel_sync || (top_q == '0)) begin
      count_d = '0;
    end else if (count_q == top_q) begin
      count_d = '0;
      woof_d  = 1'b1;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_hist_q <= SCLK_IDLE;
      sel_hist_q  <= SEL_IDLE;
      shift_q     <= '0;
      top_q       <= '0;
      count_q     <= '0;
      woof_q      <= 1'b0;
    end else begin
      sclk_hist_q <= sclk_hist_d;
      sel_hist_q  <= sel_hist_d;
      shift_q     <= shift_d;
      top_q       <= top_d;
      count_q     <= count_d;
      woof_q      <= woof_d;
    end
  end

  assign woof = woof_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// tb/tb_watchdog_timer.sv - self-checking bench for watchdog_timer
module tb_watchdog_timer;
  import watchdog_pkg::*;

  localparam int    W   = WIDTH_DEFAULT;
  localparam int    SS  = SYNC_STAGES_DEFAULT;
  localparam longint INF = 64'h3fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  logic rst;
  logic sclk;
  logic in_pin;
  logic sel;
  logic woof;

  always #10 clk = ~clk;

  watchdog_timer #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .in(in_pin), .sel(sel), .woof(woof)
  );

  int checks = 0;
  int passes = 0;

  longint cyc = 0;
  string  phase = "init";

  // Reference model: pulses fall on commit + k*(top+1), k >= 1, unless a
  // reload has paused the timer or reset is active.
  bit     m_rst    = 1'b1;
  longint m_top    = 0;
  longint m_commit = 0;
  longint m_pause  = INF;
  int     act_pulses = 0;
  int     exp_pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit exp_woof(input longint c);
    if (m_rst || m_top == 0) return 1'b0;
    if (c <= m_commit || c >= m_pause) return 1'b0;
    return ((c - m_commit) % (m_top + 1)) == 0;
  endfunction

  always @(posedge clk) begin
    bit e;
    cyc = cyc + 1;
    #2;
    e = exp_woof(cyc);
    if (woof === 1'b1) act_pulses++;
    if (e) exp_pulses++;
    check({phase, "_woof"}, {63'd0, woof}, {63'd0, e});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; sel = 1'b0; sclk = 1'b1; in_pin = 1'b0;
    m_rst = 1'b1; m_top = 0; m_pause = INF; m_commit = 0;
    tick(n);
    rst = 1'b0;
    m_rst = 1'b0;
  endtask

  function automatic int ph(input bit rnd);
    return rnd ? int'($urandom_range(3, 6)) : 4;
  endfunction

  // Sends nbits of val MSB first; abort_at >= 0 resets after that many bits.
  task automatic send_frame(input logic [63:0] val, input int nbits,
                            input int abort_at, input bit rnd);
    bit     q[$];
    longint v;
    int     start;
    @(negedge clk);
    sel = 1'b1; sclk = 1'b1;
    m_pause = cyc + 1 + SS;
    tick(ph(rnd));
    for (int i = nbits - 1; i >= 0; i--) begin
      if (abort_at >= 0 && (nbits - 1 - i) == abort_at) begin
        do_reset(5);
        return;
      end
      sclk = 1'b0; in_pin = val[i];
      tick(ph(rnd));
      sclk = 1'b1;
      tick(ph(rnd));
      q.push_back(val[i]);
    end
    sel = 1'b0; in_pin = 1'b0;
    v = 0;
    start = (q.size() > W) ? q.size() - W : 0;
    for (int k = start; k < q.size(); k++) v = v * 2 + longint'(q[k]);
    m_top = v;
    m_commit = cyc + 1 + SS;
    m_pause = INF;
  endtask

  task automatic toggle_idle(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; in_pin = 1'($urandom);
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic run(input int n);
    act_pulses = 0;
    exp_pulses = 0;
    tick(n);
    check({phase, "_pulses"}, 64'(act_pulses), 64'(exp_pulses));
  endtask

  initial begin
    logic [63:0] rv;
    int          nb;
    rst = 1'b1; sel = 1'b0; sclk = 1'b1; in_pin = 1'b0;
    tick(1);
    phase = "reset";
    do_reset(5);
    run(1000);

    phase = "load100";
    send_frame(64'd100, 32, -1, 1'b0);
    run(1500);

    phase = "reload1234";
    send_frame(64'd1234, 32, -1, 1'b0);
    run(3000);

    phase = "reload1000";
    send_frame(64'd1000, 32, -1, 1'b0);
    run(2600);

    phase = "load0";
    send_frame(64'd0, 32, -1, 1'b0);
    run(500);

    phase = "load1";
    send_frame(64'd1, 32, -1, 1'b0);
    run(100);

    phase = "bits33";
    rv = {31'd0, 1'b1, 32'd5};
    send_frame(rv, 33, -1, 1'b0);
    run(200);

    phase = "sel_low_sclk";
    toggle_idle(10);
    run(100);

    phase = "rst_mid";
    send_frame(64'd77, 32, 16, 1'b0);
    run(100);
    send_frame(64'd10, 32, -1, 1'b0);
    run(200);

    phase = "random";
    for (int r = 0; r < 8; r++) begin
      rv = {32'($urandom), 32'($urandom_range(0, 300))};
      nb = $urandom_range(20, 36);
      if (nb < 32) rv = rv & ((64'd1 << nb) - 64'd1);
      send_frame(rv, nb, -1, 1'b1);
      if (r % 3 == 1) toggle_idle(3);
      run($urandom_range(50, 800));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
